// File: rtl/sr_input_conditioner.sv
// sr_input_conditioner: synchronises and debounces raw set/clear requests and
// drives the S/R inputs of a downstream SR latch without glitches, metastable
// values or the forbidden S=R=1 combination.
// Optional build macro: SR_PULSE_MODE_EN (S/R become one-cycle pulses on a
// debounced rise instead of levels; conflict is unchanged).
module sr_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic set_in,
   input  logic clr_in,
   output logic S,
   output logic R,
   output logic conflict
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Channel index 0 = set, 1 = clr
   logic [1:0]       raw;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       db;
   logic [CNT_W-1:0] cnt [2];

   assign raw = {clr_in, set_in};

   // Two-flop synchroniser for both raw requests
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debounce: flip db only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         db <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               db[i]  <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

`ifdef SR_PULSE_MODE_EN
   logic [1:0] db_q;

   // Pulse build: one-cycle S/R on a debounced rise while the other side is low
   always_ff @(posedge clk) begin
      if (rst) begin
         db_q     <= '0;
         S        <= 1'b0;
         R        <= 1'b0;
         conflict <= 1'b0;
      end else begin
         db_q     <= db;
         S        <= db[0] & ~db_q[0] & ~db[1];
         R        <= db[1] & ~db_q[1] & ~db[0];
         conflict <= db[0] & db[1];
      end
   end
`else
   // Level build: arbitrate debounced levels; both high holds the latch
   always_ff @(posedge clk) begin
      if (rst) begin
         S        <= 1'b0;
         R        <= 1'b0;
         conflict <= 1'b0;
      end else begin
         S        <= db[0] & ~db[1];
         R        <= db[1] & ~db[0];
         conflict <= db[0] & db[1];
      end
   end
`endif

endmodule

// File: tb/tb_sr_input_conditioner.sv
// tb_sr_input_conditioner: directed scenarios plus randomized request traffic,
// checked every cycle against a history-window reference model.
module tb_sr_input_conditioner;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst;
   logic set_in;
   logic clr_in;
   logic S;
   logic R;
   logic conflict;

   int total = 0;
   int bad   = 0;

   sr_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .set_in   (set_in),
      .clr_in   (clr_in),
      .S        (S),
      .R        (R),
      .conflict (conflict)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0d exp=%0d", tag, $time, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // A debounced level flips once the synchronised stream (raw input delayed
   // by two edges) has disagreed with it for the last D edges in a row.
   logic [1:0] rawq [$];
   logic [1:0] s2q  [$];
   logic [1:0] m_db, m_prev;
   logic       m_s, m_r, m_c;

   function automatic bit window_differs(int ch, logic cur);
      if (s2q.size() < D) return 1'b0;
      for (int k = 0; k < D; k++)
         if (s2q[s2q.size() - 1 - k][ch] == cur) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      logic [1:0] s2;
      logic [1:0] nxt;
      if (rst) begin
         rawq.delete();
         s2q.delete();
         m_db = 2'b00; m_prev = 2'b00;
         m_s = 1'b0; m_r = 1'b0; m_c = 1'b0;
      end else begin
         s2 = (rawq.size() >= 2) ? rawq[rawq.size() - 2] : 2'b00;
         rawq.push_back({clr_in, set_in});
         s2q.push_back(s2);
         if (rawq.size() > 16) void'(rawq.pop_front());
         if (s2q.size() > 16)  void'(s2q.pop_front());
`ifdef SR_PULSE_MODE_EN
         m_s = m_db[0] && !m_prev[0] && !m_db[1];
         m_r = m_db[1] && !m_prev[1] && !m_db[0];
`else
         m_s = m_db[0] && !m_db[1];
         m_r = m_db[1] && !m_db[0];
`endif
         m_c = m_db[0] && m_db[1];
         nxt = m_db;
         for (int ch = 0; ch < 2; ch++)
            if (window_differs(ch, m_db[ch])) nxt[ch] = ~m_db[ch];
         m_prev = m_db;
         m_db   = nxt;
      end
   end

   // ---------------- per-cycle checker ----------------
   logic chk_en = 1'b0;
   logic cnt_en = 1'b0;
   int   s_hi = 0;
   int   r_hi = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("S", 32'(S), 32'(m_s));
         check("R", 32'(R), 32'(m_r));
         check("conflict", 32'(conflict), 32'(m_c));
         check("S_and_R", 32'(S & R), 32'd0);
      end
      if (cnt_en) begin
         s_hi += int'(S);
         r_hi += int'(R);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic window_open();
      s_hi = 0;
      r_hi = 0;
      cnt_en = 1'b1;
   endtask

   initial begin
      int hold;
      rst = 1'b1; set_in = 1'b1; clr_in = 1'b0;

      // Reset held two edges with set requested
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_S", 32'(S), 32'd0);
      check("reset_R", 32'(R), 32'd0);
      check("reset_conflict", 32'(conflict), 32'd0);
      window_open();
      @(negedge clk);
      rst = 1'b0;

      // Clean set held 20 cycles, then released
      step(20);
      set_in = 1'b0;
      step(20);
      cnt_en = 1'b0;
`ifdef SR_PULSE_MODE_EN
      check("set_hold_S_cycles", 32'(s_hi), 32'd1);
`else
      check("set_hold_S_cycles", 32'(s_hi), 32'd20);
`endif
      check("set_hold_R_cycles", 32'(r_hi), 32'd0);

      // Glitch of D-1 cycles rejected
      window_open();
      clr_in = 1'b1; step(D - 1);
      clr_in = 1'b0; step(15);
      cnt_en = 1'b0;
      check("glitch_short_R", 32'(r_hi), 32'd0);

      // Exactly D cycles passes through
      window_open();
      clr_in = 1'b1; step(D);
      clr_in = 1'b0; step(15);
      cnt_en = 1'b0;
`ifdef SR_PULSE_MODE_EN
      check("glitch_full_R", 32'(r_hi), 32'd1);
`else
      check("glitch_full_R", 32'(r_hi), 32'(D));
`endif

      // Conflict: set debounced, then clr joins, then set drops
      set_in = 1'b1; step(12);
      clr_in = 1'b1; step(12);
      check("conflict_hold", 32'(conflict), 32'd1);
      set_in = 1'b0; step(12);
      check("conflict_clear", 32'(conflict), 32'd0);
      clr_in = 1'b0; step(12);

      // Simultaneous rise
      window_open();
      set_in = 1'b1; clr_in = 1'b1; step(12);
      cnt_en = 1'b0;
      check("simul_conflict", 32'(conflict), 32'd1);
      check("simul_S_cycles", 32'(s_hi), 32'd0);
      check("simul_R_cycles", 32'(r_hi), 32'd0);
      set_in = 1'b0; clr_in = 1'b0; step(12);

      // Reset mid-debounce
      window_open();
      set_in = 1'b1; step(3);
      rst = 1'b1; step(1);
      rst = 1'b0; step(D + 1);
      cnt_en = 1'b0;
      check("mid_reset_no_S", 32'(s_hi), 32'd0);
      step(10);
      set_in = 1'b0; step(12);

      // Randomized request traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         set_in = 1'($urandom_range(0, 1));
         clr_in = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 24) == 0) rst = 1'b1;
         hold = int'($urandom_range(1, 2 * D + 2));
         step(1);
         rst = 1'b0;
         step(hold - 1);
      end

      set_in = 1'b0; clr_in = 1'b0;
      step(15);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sr_input_conditioner.md
# sr_input_conditioner

Input conditioning stage that sits directly upstream of the SR latch. It takes two raw, asynchronous set/clear requests, such as push-buttons or external lines. It synchronises and debounces each one and drives the latch's `S`/`R` inputs, so the latch never sees glitches, metastable values or the forbidden S=R=1 combination. A `conflict` flag reports when both requests are stable-high together.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive clock cycles a synchronised input must differ from its debounced level before that level flips. Legal range is ≥1.
- `CNT_W`: localparam, `$clog2(DEBOUNCE_CYCLES+1)`. Not overridable.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `set_in` input 1: raw asynchronous set request.
- `clr_in` input 1: raw asynchronous clear request.
- `S` output 1, registered: set drive to the SR latch.
- `R` output 1, registered: reset drive to the SR latch.
- `conflict` output 1, registered: both debounced requests high.

## Operation
- Per channel (set, clr): 2-flop synchroniser `sync1 -> sync2`, then a debounce counter `cnt` [CNT_W] and a debounced level `db`.
- Debounce, per edge:
  - `sync2 == db`: `cnt <= 0`.
  - `sync2 != db` and `cnt == DEBOUNCE_CYCLES-1`: `db <= sync2`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - The counter never wraps: it is cleared on flip or on any agreement.
- Output arbitration, registered, evaluated from the `db` values after the edge:
  - `db_set=1, db_clr=0`: S=1, R=0.
  - `db_set=0, db_clr=1`: S=0, R=1.
  - `db_set=1, db_clr=1`: S=0, R=0, `conflict`=1. The latch holds its value.
  - Both 0: S=0, R=0, `conflict`=0.
- Invariant: S and R are never both 1 in any cycle, including the cycle after reset.
- Reset (`rst=1` at an edge): sync flops, `db`, `cnt`, S, R and `conflict` all go to 0. A debounce in progress is discarded, and no output change results from it after reset deasserts.

## Timing
- Let edge k be the first edge at which `sync1` samples a new stable level. Then:
  - `sync2` updates at edge k+1.
  - `db` flips at edge k+1+DEBOUNCE_CYCLES.
  - S/R/`conflict` update at edge k+2+DEBOUNCE_CYCLES.
- Total latency is DEBOUNCE_CYCLES+3 edges from the first sampling edge; 7 edges with the default.
- A glitch seen at `sync2` for ≤ DEBOUNCE_CYCLES-1 consecutive cycles produces no output change.
- Simultaneous flips of both `db` at the same edge resolve by the arbitration table in the next cycle. There is no priority between channels.
- Release (1->0) uses the same latency as assertion.

## Configuration
- `SR_PULSE_MODE_EN` defined: S is a one-cycle pulse in the cycle after `db_set` rises while `db_clr` is 0 after that edge. R is a one-cycle pulse by the same rule with the channels swapped. Behaviour by case:
  - Simultaneous rises: no pulse, and `conflict` follows both `db` levels.
  - A rise while the other `db` is high: no pulse.
  - Held requests: no further pulses.
- `SR_PULSE_MODE_EN` undefined: S/R are levels per the arbitration table, as described above.
- `conflict` behaviour is identical in both builds.

## Test plan
- Reset: `rst=1` for 2 edges with `set_in=1`. Required: S=R=`conflict`=0 during reset and for DEBOUNCE_CYCLES+2 edges after release.
- Clean set, level build, default params: `set_in` rises before edge k and is held. Required: S=1 from edge k+6, R=0 throughout. Drop `set_in`: S=0 six edges after the first low sample.
- Glitch rejection: `clr_in` high for exactly 3 cycles (reaches `sync2` for 3 cycles). Required: R stays 0. Repeat with 4 cycles: R=1 for 4 cycles after latency.
- Conflict: debounced set held, then `clr_in` raised and held. Required: after latency S=0, R=0, `conflict`=1. Drop `set_in`: `conflict`=0 and R=1 after latency; S, R never both 1.
- Reset mid-debounce: `set_in` rises, `rst` pulsed 1 edge at k+3. Required: S never asserts before a full fresh DEBOUNCE_CYCLES+3 latency measured from reset release.
- Pulse build (`SR_PULSE_MODE_EN`): `set_in` held 20 cycles. Required: exactly one S pulse, 1 cycle wide, at edge k+6. Simultaneous set/clr rise: no pulses, `conflict`=1.
